// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle widths, bit positions,
// opcodes and control structs for the 5-stage datapath.
package pipeline_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_t;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_t;

  // MemtoReg is meaningless without RegWrite; the decoder may leave it floating.
  function automatic wb_t wb_sanitize(input wb_t w);
    wb_t r;
    r.regwrite = w.regwrite;
    r.memtoreg = w.regwrite & w.memtoreg;
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_stall
);

  logic w_match;

  assign w_match = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);

  assign o_stall = i_ex_valid & i_ex_memread & (i_ex_rt != '0)
                 & i_id_valid & w_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush/load-use bubbles and stall hold.
// Define ID_EX_PERF_CNT_EN to build the saturating bubble counter.
module id_ex_pipe_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [EX_W-1:0]   ex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  output logic              stall_req,
  output logic              valid_out,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [EX_W-1:0]   ex_out,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_valid;
  wb_t               r_wb;
  m_t                r_m;
  ex_t               r_ex;
  logic [DATA_W-1:0] r_npc;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  logic w_hazard;
  logic w_bubble;
  logic w_take;
  wb_t  w_wb_clean;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lud (
    .i_ex_valid  (r_valid),
    .i_ex_memread(r_m.memread),
    .i_ex_rt     (r_rt),
    .i_id_valid  (valid_in),
    .i_id_rs     (rs_in),
    .i_id_rt     (rt_in),
    .o_stall     (w_hazard)
  );

  assign stall_req  = w_hazard & ~rst;
  assign w_bubble   = flush | stall_req;
  assign w_take     = ~w_bubble & valid_in;
  assign w_wb_clean = wb_sanitize(wb_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_m     <= '0;
      r_ex    <= '0;
      r_npc   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (!hold) begin
      r_npc <= npc_in;
      r_rd1 <= rd1_in;
      r_rd2 <= rd2_in;
      r_imm <= imm_in;
      r_rt  <= rt_in;
      r_rd  <= rd_in;
      if (w_take) begin
        r_valid <= 1'b1;
        r_wb    <= w_wb_clean;
        r_m     <= m_in;
        r_ex    <= ex_in;
      end else begin
        r_valid <= 1'b0;
        r_wb    <= '0;
        r_m     <= '0;
        r_ex    <= '0;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!hold && w_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  assign bubble_cnt = '0;
`endif

  assign valid_out = r_valid;
  assign wb_out    = r_wb;
  assign m_out     = r_m;
  assign ex_out    = r_ex;
  assign npc_out   = r_npc;
  assign rd1_out   = r_rd1;
  assign rd2_out   = r_rd2;
  assign imm_out   = r_imm;
  assign rt_out    = r_rt;
  assign rd_out    = r_rd;

endmodule
